// File: rtl/apb_bank_pkg.sv
// Shared types and constants for the APB slave register bank.
// Holds the bus FSM state encoding, parameter defaults and the index-width helper.
package apb_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_SLV     = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_WAIT_STATES = 0;

  // Number of word-index bits taken from Paddr just above the byte offset.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// One DEPTH x DATA_W register bank with byte-strobe write and registered read.
// The read register returns to zero whenever no read is requested.
module apb_slv_mem
  import apb_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      rdata <= rd_en ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/apb_slave_bank.sv
// APB slave fronting NUM_SLV independent register banks, one per Pselx line.
// The FSM follows the bus one cycle behind; Pready/Pslverr/Prdata are registered.
//
// state     | meaning
// ST_IDLE   | no transfer; waiting for Pselx!=0 with Penable=0
// ST_SETUP  | request captured; waiting for Penable=1
// ST_ACCESS | counting wait states; Pready=1 marks the completion cycle
module apb_slave_bank
  import apb_bank_pkg::*;
#(
  parameter int NUM_SLV     = DEF_NUM_SLV,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                clk,
  input  logic                Presetn,
  input  logic [NUM_SLV-1:0]  Pselx,
  input  logic                Penable,
  input  logic                Pwrite,
  input  logic [ADDR_W-1:0]   Paddr,
  input  logic [DATA_W-1:0]   Pwdata,
  input  logic [DATA_W/8-1:0] Pstrb,
  output logic [DATA_W-1:0]   Prdata,
  output logic                Pready,
  output logic                Pslverr
);

  localparam int IDX_W  = idx_width(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  apb_state_e          state_q;
  logic [2:0]          cnt_q;
  logic                pready_q;
  logic                pslverr_q;
  logic [NUM_SLV-1:0]  sel_q;
  logic                write_q;
  logic                err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic                sel_any;
  logic                sel_onehot;
  logic                addr_err;
  logic                bus_setup;
  logic                in_cmp;
  logic                enter_cmp;
  logic                capture;
  logic [NUM_SLV-1:0]  wr_en;
  logic [NUM_SLV-1:0]  rd_en;
  logic [DATA_W-1:0]   bank_rdata [NUM_SLV];

  assign sel_any    = |Pselx;
  assign sel_onehot = sel_any && ((Pselx & (Pselx - NUM_SLV'(1))) == '0);
  assign addr_err   = (Paddr[1:0] != 2'b00) || ((Paddr >> (IDX_W + 2)) != '0);
  assign bus_setup  = sel_any && !Penable;
  assign in_cmp     = (state_q == ST_ACCESS) && pready_q;

  // Pready is registered, so the completion cycle is scheduled one edge early.
  assign enter_cmp = ((state_q == ST_SETUP) && Penable && sel_any && (WAIT_STATES == 0)) ||
                     ((state_q == ST_ACCESS) && !pready_q && sel_any && (cnt_q == 3'd1));

  assign capture = bus_setup && ((state_q == ST_IDLE) || in_cmp);

  assign wr_en = (in_cmp && write_q && !err_q) ? sel_q : '0;
  assign rd_en = (enter_cmp && !write_q && !err_q) ? sel_q : '0;

  always_ff @(posedge clk or negedge Presetn) begin
    if (!Presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      sel_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      pready_q  <= enter_cmp;
      pslverr_q <= enter_cmp && err_q;

      if (capture) begin
        sel_q   <= Pselx;
        write_q <= Pwrite;
        err_q   <= addr_err || !sel_onehot;
        idx_q   <= Paddr[IDX_W+1:2];
        wdata_q <= Pwdata;
        strb_q  <= Pstrb;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus_setup) state_q <= ST_SETUP;
        end
        ST_SETUP: begin
          if (!sel_any) begin
            state_q <= ST_IDLE;
          end else if (Penable) begin
            state_q <= ST_ACCESS;
            cnt_q   <= 3'(WAIT_STATES);
          end
        end
        ST_ACCESS: begin
          if (pready_q) begin
            state_q <= bus_setup ? ST_SETUP : ST_IDLE;
            cnt_q   <= '0;
          end else if (!sel_any) begin
            // master withdrew before completion: drop the transfer
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_bank
    apb_slv_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_mem (
      .clk   (clk),
      .rst_n (Presetn),
      .wr_en (wr_en[k]),
      .rd_en (rd_en[k]),
      .idx   (idx_q),
      .wdata (wdata_q),
      .strb  (strb_q),
      .rdata (bank_rdata[k])
    );
  end

  // Only the bank being read holds nonzero read data, so OR-ing them selects it.
  always_comb begin
    Prdata = '0;
    for (int k = 0; k < NUM_SLV; k++) Prdata = Prdata | bank_rdata[k];
  end

  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Bench for apb_slave_bank: three instances with 0, 2 and 3 wait states, each on its
// own bus, checked against an array model of the banks and the address rules.
module tb_apb_slave_bank;

  logic        clk = 1'b0;
  logic        Presetn;
  logic [3:0]  psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic [31:0] mdl [3][4][16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_bank #(
      .NUM_SLV     (4),
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH       (16),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .clk     (clk),
      .Presetn (Presetn),
      .Pselx   (psel[g]),
      .Penable (penable[g]),
      .Pwrite  (pwrite[g]),
      .Paddr   (paddr[g]),
      .Pwdata  (pwdata[g]),
      .Pstrb   (pstrb[g]),
      .Prdata  (prdata[g]),
      .Pready  (pready[g]),
      .Pslverr (pslverr[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_model();
    for (int d = 0; d < 3; d++)
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 16; i++) mdl[d][b][i] = '0;
  endtask

  task automatic bus_idle(input int d);
    psel[d] = '0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
  endtask

  // One transfer; starts either idle or in the previous completion cycle.
  // With go_idle=0 it returns in its own completion cycle for back-to-back use.
  task automatic apb_xfer(input int d, input bit wr, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit go_idle,
                          output logic [31:0] rd);
    int n;
    int bank;
    int idx;
    bit err;
    logic [31:0] exp_rd;
    err  = (addr % 4 != 0) || (addr >= 32'd64) || ($countones(sel) != 1);
    bank = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) bank = b;
    idx  = int'(addr / 4) % 16;
    psel[d] = sel; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    // anything but the select may wander once the request is captured
    paddr[d] = $urandom(); pwdata[d] = $urandom();
    pstrb[d] = 4'($urandom_range(0, 15)); pwrite[d] = ~wr;
    @(posedge clk); #1;
    n = 1;
    while (pready[d] !== 1'b1 && n <= 12) begin
      chk("wait_prdata", prdata[d], 32'h0);
      @(posedge clk); #1;
      n++;
    end
    chk("ready_cycle", 32'(n), 32'(ws_of(d) + 1));
    exp_rd = (wr || err) ? 32'h0 : mdl[d][bank][idx];
    chk("slverr", {31'b0, pslverr[d]}, {31'b0, err});
    chk("prdata", prdata[d], exp_rd);
    rd = prdata[d];
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[d][bank][idx][b*8 +: 8] = wdata[b*8 +: 8];
    if (go_idle) begin
      bus_idle(d);
      @(posedge clk); #1;
      chk("idle_ready", {31'b0, pready[d]}, 32'h0);
      chk("idle_prdata", prdata[d], 32'h0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int d;
    bit chained;
    bit wr;
    bit go_idle;
    logic [3:0] sel;
    logic [31:0] addr;

    for (int i = 0; i < 3; i++) bus_idle(i);
    clr_model();
    Presetn = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", {31'b0, pready[i]}, 32'h0);
      chk("rst_slverr", {31'b0, pslverr[i]}, 32'h0);
      chk("rst_prdata", prdata[i], 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 Presetn = 1'b1;
    @(posedge clk); #1;

    // basic write/read, zero wait states
    apb_xfer(0, 1'b1, 4'b0010, 32'h8, 32'hDEADBEEF, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b0, 4'b0010, 32'h8, 32'h0, 4'h0, 1'b1, rd);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // three wait states, reset location
    apb_xfer(2, 1'b0, 4'b0100, 32'h1C, 32'h0, 4'h0, 1'b1, rd);
    chk("rd_w3_zero", rd, 32'h0);

    // partial strobes
    apb_xfer(0, 1'b1, 4'b0001, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b1, 4'b0001, 32'h10, 32'h11223344, 4'b0101, 1'b1, rd);
    apb_xfer(0, 1'b1, 4'b0001, 32'h10, 32'h99999999, 4'b0000, 1'b1, rd);
    apb_xfer(0, 1'b0, 4'b0001, 32'h10, 32'h0, 4'h0, 1'b1, rd);
    chk("rd_strobe", rd, 32'hFF22FF44);

    // error cases leave every bank untouched
    apb_xfer(0, 1'b1, 4'b0001, 32'h0, 32'hCAFE0001, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b1, 4'b0010, 32'h0, 32'hCAFE0002, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b1, 4'b0001, 32'h40, 32'hBAD00000, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b1, 4'b0001, 32'h2, 32'hBAD00001, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b1, 4'b0011, 32'h0, 32'hBAD00002, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b0, 4'b0011, 32'h0, 32'h0, 4'h0, 1'b1, rd);
    apb_xfer(0, 1'b0, 4'b0001, 32'h0, 32'h0, 4'h0, 1'b1, rd);
    chk("err_bank0", rd, 32'hCAFE0001);
    apb_xfer(0, 1'b0, 4'b0010, 32'h0, 32'h0, 4'h0, 1'b1, rd);
    chk("err_bank1", rd, 32'hCAFE0002);

    // back-to-back write then read with no idle cycle between
    apb_xfer(1, 1'b1, 4'b1000, 32'h24, 32'h5A5A1234, 4'hF, 1'b0, rd);
    apb_xfer(1, 1'b0, 4'b1000, 32'h24, 32'h0, 4'h0, 1'b1, rd);
    chk("b2b_read", rd, 32'h5A5A1234);

    // Penable high while idle is not a transfer
    psel[0] = 4'b0001; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'h77777777; pstrb[0] = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_en_ready", {31'b0, pready[0]}, 32'h0);
    end
    bus_idle(0);
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 4'b0001, 32'h4, 32'h0, 4'h0, 1'b1, rd);

    // select withdrawn mid-access aborts the write
    psel[2] = 4'b0100; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'hC; pwdata[2] = 32'hABCDEF01; pstrb[2] = 4'hF;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    bus_idle(2);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_ready", {31'b0, pready[2]}, 32'h0);
    end
    apb_xfer(2, 1'b0, 4'b0100, 32'hC, 32'h0, 4'h0, 1'b1, rd);
    chk("abort_nowrite", rd, 32'h0);

    // randomized traffic against the model
    chained = 1'b0;
    d = 0;
    for (int t = 0; t < 60; t++) begin
      if (!chained) d = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sel = 4'($urandom_range(1, 15));
      else sel = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr = 32'($urandom_range(0, 127));
      else addr = 32'($urandom_range(0, 15) * 4);
      go_idle = (t == 59) ? 1'b1 : 1'($urandom_range(0, 1));
      apb_xfer(d, wr, sel, addr, $urandom(), 4'($urandom_range(0, 15)), go_idle, rd);
      chained = !go_idle;
    end

    // reset during a completion cycle clears outputs without a clock edge
    apb_xfer(0, 1'b1, 4'b0100, 32'h30, 32'hA5A5C3C3, 4'hF, 1'b1, rd);
    apb_xfer(0, 1'b0, 4'b0100, 32'h30, 32'h0, 4'h0, 1'b0, rd);
    chk("pre_rst_data", rd, 32'hA5A5C3C3);
    Presetn = 1'b0;
    #1;
    chk("async_ready", {31'b0, pready[0]}, 32'h0);
    chk("async_prdata", prdata[0], 32'h0);
    chk("async_slverr", {31'b0, pslverr[0]}, 32'h0);
    clr_model();
    bus_idle(0);
    @(posedge clk); #1;
    Presetn = 1'b1;
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 4'b0100, 32'h30, 32'h0, 4'h0, 1'b1, rd);
    chk("post_rst_clear", rd, 32'h0);

    // reset in the middle of a two-wait-state write discards it
    psel[1] = 4'b0001; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h14; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_ready", {31'b0, pready[1]}, 32'h0);
    Presetn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, pready[1]}, 32'h0);
    chk("mid_rst_prdata", prdata[1], 32'h0);
    clr_model();
    bus_idle(1);
    @(posedge clk); @(posedge clk); #1;
    Presetn = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1, 1'b0, 4'b0001, 32'h14, 32'h0, 4'h0, 1'b1, rd);
    chk("mid_rst_nowrite", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
